// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types, width codes and FSM encoding for the memory controller.
`default_nettype none
package mem_ctrl_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  localparam word_t ZERO_WORD = 32'h0000_0000;
  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      LS_BYTE: width_bytes = 3'd1;
      LS_HALF: width_bytes = 3'd2;
      default: width_bytes = 3'd4;
    endcase
  endfunction
endpackage
`default_nettype wire

// File: rtl/mem_ctrl_ext.sv
// mem_ctrl_ext: byte/half/word sign or zero extension of an assembled load word.
`default_nettype none
module mem_ctrl_ext
  import mem_ctrl_pkg::*;
(
  input  word_t      word_i,
  input  logic [1:0] width_i,
  input  logic       signed_i,
  output word_t      word_o
);
  always_comb begin
    word_o = word_i;
    case (width_i)
      LS_BYTE: word_o = {{24{signed_i & word_i[7]}}, word_i[7:0]};
      LS_HALF: word_o = {{16{signed_i & word_i[15]}}, word_i[15:0]};
      default: word_o = word_i;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves word fetches and load/store requests over a byte-wide RAM/IO bus.
`default_nettype none
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int IO_SEL_HI = 17,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear_flag_in,
  input  logic              if_fetch_enable_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_result_enable_out,
  output word_t             if_data_out,
  input  logic              lsb_enable_in,
  input  logic              lsb_wr_in,
  input  logic [1:0]        lsb_width_in,
  input  logic              lsb_signed_in,
  input  logic [ADDR_W-1:0] lsb_addr_in,
  input  word_t             lsb_data_in,
  output logic              lsb_result_enable_out,
  output word_t             lsb_data_out,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);
  state_e            state_q;
  logic              is_fetch_q, resume_q, signed_q;
  logic [1:0]        width_q;
  logic [ADDR_W-1:0] addr_q;
  word_t             sdata_q, word_q;
  logic [2:0]        nbytes_q, iss_q, cap_q;
  logic              if_res_q, lsb_res_q;
  word_t             if_data_q, lsb_data_q;

  logic              io_addr, rd_issue, wr_issue, rd_capture;
  logic [2:0]        rd_idx;
  word_t             word_d, ext_word;

  // After a pause the pending byte is re-addressed from the capture index.
  always_comb begin
    io_addr    = (addr_q[IO_SEL_HI -: 2] == 2'b11);
    rd_idx     = resume_q ? cap_q : iss_q;
    rd_issue   = (state_q == READ) && rdy && (rd_idx < nbytes_q);
    wr_issue   = (state_q == WRITE) && rdy && !(io_addr && io_buffer_full);
    rd_capture = (state_q == READ) && rdy && !resume_q && (cap_q < iss_q);
    word_d     = word_q;
    word_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    if (rd_issue) begin
      mem_a = addr_q + ADDR_W'(rd_idx);
    end else if (wr_issue) begin
      mem_a    = addr_q + ADDR_W'(iss_q);
      mem_wr   = 1'b1;
      mem_dout = sdata_q[{iss_q[1:0], 3'b000} +: 8];
    end
  end

  mem_ctrl_ext u_ext (
    .word_i   (word_d),
    .width_i  (width_q),
    .signed_i (signed_q),
    .word_o   (ext_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_fetch_q <= FALSE;
      resume_q   <= FALSE;
      signed_q   <= FALSE;
      width_q    <= LS_BYTE;
      addr_q     <= '0;
      sdata_q    <= ZERO_WORD;
      word_q     <= ZERO_WORD;
      nbytes_q   <= 3'd0;
      iss_q      <= 3'd0;
      cap_q      <= 3'd0;
      if_res_q   <= FALSE;
      lsb_res_q  <= FALSE;
      if_data_q  <= ZERO_WORD;
      lsb_data_q <= ZERO_WORD;
    end else if (!rdy) begin
      resume_q <= TRUE;
    end else begin
      resume_q <= FALSE;
      case (state_q)
        IDLE: begin
          if (!clear_flag_in) begin
            iss_q  <= 3'd0;
            cap_q  <= 3'd0;
            word_q <= ZERO_WORD;
            if (lsb_enable_in) begin
              is_fetch_q <= FALSE;
              width_q    <= lsb_width_in;
              signed_q   <= lsb_signed_in;
              addr_q     <= lsb_addr_in;
              sdata_q    <= lsb_data_in;
              nbytes_q   <= width_bytes(lsb_width_in);
              state_q    <= lsb_wr_in ? WRITE : READ;
            end else if (if_fetch_enable_in) begin
              is_fetch_q <= TRUE;
              width_q    <= LS_WORD;
              signed_q   <= FALSE;
              addr_q     <= if_addr_in;
              nbytes_q   <= 3'd4;
              state_q    <= READ;
            end
          end
        end
        READ: begin
          if (clear_flag_in) begin
            state_q <= IDLE;
          end else begin
            if (rd_issue) iss_q <= rd_idx + 3'd1;
            if (rd_capture) begin
              word_q <= word_d;
              cap_q  <= cap_q + 3'd1;
              if (cap_q == nbytes_q - 3'd1) begin
                state_q <= DONE;
                if (is_fetch_q) begin
                  if_res_q  <= TRUE;
                  if_data_q <= word_d;
                end else begin
                  lsb_res_q  <= TRUE;
                  lsb_data_q <= ext_word;
                end
              end
            end
          end
        end
        WRITE: begin
          if (wr_issue) begin
            iss_q <= iss_q + 3'd1;
            if (iss_q == nbytes_q - 3'd1) begin
              state_q   <= DONE;
              lsb_res_q <= TRUE;
            end
          end
        end
        DONE: begin
          if_res_q  <= FALSE;
          lsb_res_q <= FALSE;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_result_enable_out  = if_res_q;
  assign if_data_out           = if_data_q;
  assign lsb_result_enable_out = lsb_res_q;
  assign lsb_data_out          = lsb_data_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed stimulus checked cycle-by-cycle against a transaction-level model.
`default_nettype none
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, clear_flag_in;
  logic        if_fetch_enable_in, if_result_enable_out;
  logic [31:0] if_addr_in, if_data_out;
  logic        lsb_enable_in, lsb_wr_in, lsb_signed_in, lsb_result_enable_out;
  logic [1:0]  lsb_width_in;
  logic [31:0] lsb_addr_in, lsb_data_in, lsb_data_out;
  logic        io_buffer_full, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;

  mem_ctrl #(.IO_SEL_HI(17), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_flag_in(clear_flag_in),
    .if_fetch_enable_in(if_fetch_enable_in), .if_addr_in(if_addr_in),
    .if_result_enable_out(if_result_enable_out), .if_data_out(if_data_out),
    .lsb_enable_in(lsb_enable_in), .lsb_wr_in(lsb_wr_in), .lsb_width_in(lsb_width_in),
    .lsb_signed_in(lsb_signed_in), .lsb_addr_in(lsb_addr_in), .lsb_data_in(lsb_data_in),
    .lsb_result_enable_out(lsb_result_enable_out), .lsb_data_out(lsb_data_out),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Bus environment memory (written by the DUT) and the model's own memory image.
  logic [7:0]  env_ram [logic [31:0]];
  logic [7:0]  mdl_ram [logic [31:0]];
  // Expected per-cycle bus activity and result pulses, keyed by cycle number.
  logic [31:0] exp_a   [int];
  bit          exp_w   [int];
  logic [7:0]  exp_d   [int];
  logic [31:0] exp_ifd [int];
  logic [31:0] exp_lsbd[int];
  bit          exp_ifp [int];
  bit          exp_lsbp[int];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_ram.exists(a) ? env_ram[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl_ram.exists(a) ? mdl_ram[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (mem_wr) env_ram[mem_a] = mem_dout;
    mem_din <= env_rd(mem_a);
  end

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    env_ram[a] = b;
    mdl_ram[a] = b;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] width, input bit sgn);
    logic [31:0] v;
    v = w;
    if (width == 2'b00) begin
      v = w % 256;
      if (sgn && v >= 128) v = v - 256;
    end else if (width == 2'b01) begin
      v = w % 65536;
      if (sgn && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic void plan_read(input int c0, input logic [31:0] addr, input int n,
                                    input bit is_if, input logic [1:0] width, input bit sgn);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < n; k++) begin
      exp_a[c0 + 1 + k] = addr + 32'(k);
      w = w + (32'(mdl_rd(addr + 32'(k))) << (8 * k));
    end
    if (is_if) begin
      exp_ifp[c0 + n + 2] = 1'b1;
      exp_ifd[c0 + n + 2] = w;
    end else begin
      exp_lsbp[c0 + n + 2] = 1'b1;
      exp_lsbd[c0 + n + 2] = extend(w, width, sgn);
    end
  endfunction

  function automatic void plan_write(input int c0, input logic [31:0] addr, input int n,
                                     input logic [31:0] data, input int stall);
    for (int k = 0; k < n; k++) begin
      exp_a[c0 + 1 + stall + k] = addr + 32'(k);
      exp_w[c0 + 1 + stall + k] = 1'b1;
      exp_d[c0 + 1 + stall + k] = 8'((data >> (8 * k)) % 256);
      mdl_ram[addr + 32'(k)]    = 8'((data >> (8 * k)) % 256);
    end
    exp_lsbp[c0 + n + 1 + stall] = 1'b1;
  endfunction

  logic [31:0] ea;
  bit          ew, ifp, lsbp;
  always @(negedge clk) begin
    if (chk_en) begin
      ea   = exp_a.exists(cyc) ? exp_a[cyc] : 32'h0;
      ew   = exp_w.exists(cyc) ? exp_w[cyc] : 1'b0;
      ifp  = exp_ifp.exists(cyc) ? 1'b1 : 1'b0;
      lsbp = exp_lsbp.exists(cyc) ? 1'b1 : 1'b0;
      check("mem_a", mem_a, ea);
      check("mem_wr", 32'(mem_wr), 32'(ew));
      if (ew) check("mem_dout", 32'(mem_dout), 32'(exp_d[cyc]));
      check("if_pulse", 32'(if_result_enable_out), 32'(ifp));
      if (ifp) check("if_data", if_data_out, exp_ifd[cyc]);
      check("lsb_pulse", 32'(lsb_result_enable_out), 32'(lsbp));
      if (lsbp && exp_lsbd.exists(cyc)) check("lsb_data", lsb_data_out, exp_lsbd[cyc]);
    end
  end

  task automatic wait_pulse(input bit is_if, input int c0, input int stall, input int p_at,
                            input int p_len, output int pc, output logic [31:0] got);
    pc  = -1;
    got = 32'h0;
    for (int i = 0; i < 80 && pc < 0; i++) begin
      @(posedge clk); #1;
      if (stall > 0 && cyc == c0 + stall + 1) io_buffer_full = 1'b0;
      if (p_len > 0 && cyc == c0 + p_at) rdy = 1'b0;
      if (p_len > 0 && cyc == c0 + p_at + p_len) rdy = 1'b1;
      if (is_if ? if_result_enable_out : lsb_result_enable_out) begin
        pc  = cyc;
        got = is_if ? if_data_out : lsb_data_out;
      end
    end
    if (pc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pulse_timeout is_if=%0d c0=%0d actual=none expected=pulse", is_if, c0);
    end
  endtask

  task automatic txn(input int kind, input logic [31:0] addr, input logic [1:0] width, input bit sgn,
                     input logic [31:0] data, input int stall,
                     output int c0, output int pc, output logic [31:0] got);
    @(posedge clk); #1;
    c0 = cyc;
    if (kind == 0) begin
      if_fetch_enable_in = 1'b1;
      if_addr_in         = addr;
      plan_read(c0, addr, 4, 1'b1, 2'b10, 1'b0);
    end else begin
      lsb_enable_in = 1'b1;
      lsb_wr_in     = (kind == 2);
      lsb_width_in  = width;
      lsb_signed_in = sgn;
      lsb_addr_in   = addr;
      lsb_data_in   = data;
      if (kind == 2) plan_write(c0, addr, nbytes(width), data, stall);
      else           plan_read(c0, addr, nbytes(width), 1'b0, width, sgn);
    end
    if (stall > 0) io_buffer_full = 1'b1;
    wait_pulse(kind == 0, c0, stall, 0, 0, pc, got);
    @(posedge clk); #1;
    if_fetch_enable_in = 1'b0;
    lsb_enable_in      = 1'b0;
  endtask

  int          c0, pc, pc2, kind, stall;
  logic [31:0] got, addr;
  logic [1:0]  width;

  initial begin
    rst = 1'b1; rdy = 1'b1; clear_flag_in = 1'b0; io_buffer_full = 1'b0;
    if_fetch_enable_in = 1'b0; if_addr_in = 32'h0;
    lsb_enable_in = 1'b0; lsb_wr_in = 1'b0; lsb_width_in = 2'b00; lsb_signed_in = 1'b0;
    lsb_addr_in = 32'h0; lsb_data_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_if_pulse", 32'(if_result_enable_out), 32'h0);
    check("rst_lsb_pulse", 32'(lsb_result_enable_out), 32'h0);
    check("rst_if_data", if_data_out, 32'h0);
    check("rst_lsb_data", lsb_data_out, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Fetch of a known instruction.
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'hA0); poke(32'h103, 8'h00);
    txn(0, 32'h100, 2'b10, 1'b0, 32'h0, 0, c0, pc, got);
    check("fetch_data", got, 32'h00A00513);
    check("fetch_latency", 32'(pc - c0), 32'd6);

    // Signed and unsigned byte loads.
    poke(32'h20, 8'h80);
    txn(1, 32'h20, 2'b00, 1'b1, 32'h0, 0, c0, pc, got);
    check("lb_data", got, 32'hFFFFFF80);
    check("lb_latency", 32'(pc - c0), 32'd3);
    txn(1, 32'h20, 2'b00, 1'b0, 32'h0, 0, c0, pc, got);
    check("lbu_data", got, 32'h00000080);

    // Half store, plain and to a stalled IO address.
    txn(2, 32'h40, 2'b01, 1'b0, 32'h1234ABCD, 0, c0, pc, got);
    check("sh_latency", 32'(pc - c0), 32'd3);
    check("sh_byte0", 32'(env_rd(32'h40)), 32'hCD);
    check("sh_byte1", 32'(env_rd(32'h41)), 32'hAB);
    txn(2, 32'h30000, 2'b01, 1'b0, 32'h1234ABCD, 3, c0, pc, got);
    check("sh_io_latency", 32'(pc - c0), 32'd6);
    check("sh_io_byte1", 32'(env_rd(32'h30001)), 32'hAB);

    // Word load wrapping past the top of the address space.
    txn(1, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h0, 0, c0, pc, got);

    // Simultaneous requests: load first, fetch after.
    @(posedge clk); #1;
    c0 = cyc;
    lsb_enable_in = 1'b1; lsb_wr_in = 1'b0; lsb_width_in = 2'b10; lsb_signed_in = 1'b0;
    lsb_addr_in = 32'h500;
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h600;
    plan_read(c0, 32'h500, 4, 1'b0, 2'b10, 1'b0);
    plan_read(c0 + 7, 32'h600, 4, 1'b1, 2'b10, 1'b0);
    wait_pulse(1'b0, c0, 0, 0, 0, pc, got);
    @(posedge clk); #1;
    lsb_enable_in = 1'b0;
    wait_pulse(1'b1, c0, 0, 0, 0, pc2, got);
    @(posedge clk); #1;
    if_fetch_enable_in = 1'b0;
    check("cont_lsb_latency", 32'(pc - c0), 32'd6);
    check("cont_if_after_lsb", 32'(pc2 - pc), 32'd7);

    // Flush during the third byte of a fetch, then a fresh fetch.
    @(posedge clk); #1;
    c0 = cyc;
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h180;
    for (int k = 0; k < 3; k++) exp_a[c0 + 1 + k] = 32'h180 + 32'(k);
    while (cyc < c0 + 3) begin @(posedge clk); #1; end
    clear_flag_in = 1'b1;
    @(posedge clk); #1;
    clear_flag_in = 1'b0; if_fetch_enable_in = 1'b0;
    check("flush_bus_idle", mem_a, 32'h0);
    repeat (4) @(posedge clk);
    poke(32'h200, 8'h78); poke(32'h201, 8'h56); poke(32'h202, 8'h34); poke(32'h203, 8'h12);
    txn(0, 32'h200, 2'b10, 1'b0, 32'h0, 0, c0, pc, got);
    check("post_flush_data", got, 32'h12345678);

    // Two-cycle pause in the middle of a word load.
    poke(32'h300, 8'h44); poke(32'h301, 8'h33); poke(32'h302, 8'h22); poke(32'h303, 8'h11);
    @(posedge clk); #1;
    c0 = cyc;
    lsb_enable_in = 1'b1; lsb_wr_in = 1'b0; lsb_width_in = 2'b10; lsb_signed_in = 1'b0;
    lsb_addr_in = 32'h300;
    exp_a[c0 + 1] = 32'h300; exp_a[c0 + 2] = 32'h301;
    exp_a[c0 + 5] = 32'h301; exp_a[c0 + 6] = 32'h302; exp_a[c0 + 7] = 32'h303;
    exp_lsbp[c0 + 9] = 1'b1; exp_lsbd[c0 + 9] = 32'h11223344;
    wait_pulse(1'b0, c0, 0, 3, 2, pc, got);
    @(posedge clk); #1;
    lsb_enable_in = 1'b0;
    check("pause_data", got, 32'h11223344);

    // Reset in the middle of a fetch.
    @(posedge clk); #1;
    c0 = cyc;
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h100;
    exp_a[c0 + 1] = 32'h100; exp_a[c0 + 2] = 32'h101;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; if_fetch_enable_in = 1'b0;
    check("midrst_mem_a", mem_a, 32'h0);
    check("midrst_if_data", if_data_out, 32'h0);
    repeat (8) @(posedge clk);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      kind  = int'($urandom_range(0, 2));
      width = 2'($urandom_range(0, 2));
      addr  = 32'($urandom_range(0, 255));
      stall = 0;
      if (kind == 2 && $urandom_range(0, 3) == 0) begin
        addr  = 32'h00030000 | addr;
        stall = int'($urandom_range(0, 4));
      end
      txn(kind, addr, width, 1'($urandom_range(0, 1)), $urandom, stall, c0, pc, got);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
